// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the IF fetch controller
// (master) and the instruction memory (slave).
interface if_fetch_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, runs req/ack fetches with a wait-state
// watchdog, absorbs mid-flight branch redirects and feeds a one-entry buffer.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_addr,
  input  logic                  freeze,
  if_fetch_ctrl_if.master       mem,
  output logic                  inst_valid,
  output logic [31:0]           inst,
  output logic [31:0]           pc,
  output logic                  mem_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  state_t           state;
  logic [31:0]      pc_reg;
  logic [31:0]      pend_pc;
  logic             mem_req_q;
  logic [CNT_W-1:0] wait_cnt;

  logic [31:0]      fetch_addr;
  logic [CNT_W-1:0] wait_inc;
  logic             timeout;

  // pc_reg addresses the outstanding request; a redirect arriving during an
  // unacked request parks its target in pend_pc so mem_addr stays stable.
  assign fetch_addr   = {pc_reg[31:2], 2'b00};
  assign mem.mem_addr = fetch_addr;
  assign mem.mem_req  = mem_req_q;

  assign wait_inc = wait_cnt + 1'b1;
  assign timeout  = (MAX_WAIT != 0) && mem_req_q && !mem.mem_ack &&
                    (wait_inc == WAIT_LIMIT);

  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the same pre-edge snapshot, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc_reg     <= RESET_PC;
      pend_pc    <= 32'd0;
      mem_req_q  <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      pc         <= 32'd0;
      mem_err    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (branch_taken) pc_reg <= branch_addr;
          mem_req_q <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_REQ;
        end

        S_REQ: begin
          if (timeout) begin
            mem_req_q <= 1'b0;
            mem_err   <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_ERR;
          end else if (branch_taken) begin
            wait_cnt <= '0;
            if (mem.mem_ack) begin
              // Old fetch completes this edge; drop it and re-request at the target.
              pc_reg <= branch_addr;
            end else begin
              pend_pc <= branch_addr;
              state   <= S_DRAIN;
            end
          end else if (mem.mem_ack) begin
            inst       <= mem.mem_rdata;
            pc         <= fetch_addr + 32'd4;
            inst_valid <= 1'b1;
            pc_reg     <= pc_reg + 32'd4;
            mem_req_q  <= 1'b0;
            wait_cnt   <= '0;
            state      <= S_HOLD;
          end else begin
            wait_cnt <= wait_inc;
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            pc_reg     <= branch_addr;
            inst_valid <= 1'b0;
            mem_req_q  <= 1'b1;
            state      <= S_REQ;
          end else if (!freeze) begin
            inst_valid <= 1'b0;
            mem_req_q  <= 1'b1;
            state      <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (timeout) begin
            mem_req_q <= 1'b0;
            mem_err   <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_ERR;
          end else if (mem.mem_ack) begin
            pc_reg   <= branch_taken ? branch_addr : pend_pc;
            wait_cnt <= '0;
            state    <= S_REQ;
          end else begin
            if (branch_taken) pend_pc <= branch_addr;
            wait_cnt <= wait_inc;
          end
        end

        S_ERR: begin
          mem_req_q  <= 1'b0;
          inst_valid <= 1'b0;
          mem_err    <= 1'b1;
        end

        default: begin
          mem_req_q  <= 1'b0;
          inst_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: dut_a uses default parameters, dut_b uses
// RESET_PC=0xFFFFFFFC and MAX_WAIT=4. Memory data is always addr ^ 0xA5.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        branch_taken, freeze;
  logic [31:0] branch_addr;
  logic        auto_a, ack_a, auto_b, ack_b;

  logic        valid_a, err_a, valid_b, err_b;
  logic [31:0] inst_a, pc_a, inst_b, pc_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl_if bus_a ();
  if_fetch_ctrl_if bus_b ();

  // auto mode acks in the same cycle as the request (zero-wait memory).
  assign bus_a.mem_ack   = auto_a ? bus_a.mem_req : ack_a;
  assign bus_a.mem_rdata = bus_a.mem_addr ^ 32'h0000_00A5;
  assign bus_b.mem_ack   = auto_b ? bus_b.mem_req : ack_b;
  assign bus_b.mem_rdata = bus_b.mem_addr ^ 32'h0000_00A5;

  if_fetch_ctrl dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .freeze       (freeze),
    .mem          (bus_a),
    .inst_valid   (valid_a),
    .inst         (inst_a),
    .pc           (pc_a),
    .mem_err      (err_a)
  );

  if_fetch_ctrl #(
    .RESET_PC (32'hFFFF_FFFC),
    .MAX_WAIT (4),
    .CNT_W    (5)
  ) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .freeze       (freeze),
    .mem          (bus_b),
    .inst_valid   (valid_b),
    .inst         (inst_b),
    .pc           (pc_b),
    .mem_err      (err_b)
  );

  // NOTE: inputs change and outputs are sampled only at negedge, so nothing
  // races the rising edge the DUT registers on.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b0; auto_a = 1'b0; ack_a = 1'b0;
    branch_taken = 1'b0; branch_addr = 32'd0; freeze = 1'b0;
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus_a.mem_req, valid_a, err_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus_a.mem_req, valid_a, err_a});
    end
    checks++;
    if ({inst_a, pc_a, bus_a.mem_addr} !== 96'd0) begin
      errors++; $display("FAIL reset_data: inst=%h pc=%h addr=%h want all 0", inst_a, pc_a, bus_a.mem_addr);
    end
    rst_a = 1'b1;
    checks++;
    if (bus_a.mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req: got %b want 0", bus_a.mem_req);
    end
  endtask

  task automatic test_zero_wait();
    auto_a = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c % 2 == 1) begin
        checks++;
        if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'(2 * (c - 1))) begin
          errors++;
          $display("FAIL zw_req c%0d: req=%b valid=%b addr=%h want 1 0 %h",
                   c, bus_a.mem_req, valid_a, bus_a.mem_addr, 32'(2 * (c - 1)));
        end
      end else begin
        checks++;
        if ({bus_a.mem_req, valid_a} !== 2'b01 || inst_a !== (32'(2 * (c - 2)) ^ 32'hA5) ||
            pc_a !== 32'(2 * c)) begin
          errors++;
          $display("FAIL zw_hold c%0d: req=%b valid=%b inst=%h pc=%h want 0 1 %h %h",
                   c, bus_a.mem_req, valid_a, inst_a, pc_a, 32'(2 * (c - 2)) ^ 32'hA5, 32'(2 * c));
        end
      end
    end
    auto_a = 1'b0;
    ack_a  = 1'b0;
  endtask

  task automatic test_wait_and_freeze();
    for (int c = 7; c <= 10; c++) begin
      tick();
      checks++;
      if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h0000_000C) begin
        errors++;
        $display("FAIL wait_req c%0d: req=%b valid=%b addr=%h want 1 0 0000000c",
                 c, bus_a.mem_req, valid_a, bus_a.mem_addr);
      end
    end
    ack_a  = 1'b1;
    freeze = 1'b1;
    tick();
    ack_a = 1'b0;
    for (int c = 11; c <= 15; c++) begin
      if (c > 11) tick();
      checks++;
      if ({bus_a.mem_req, valid_a} !== 2'b01 || inst_a !== 32'h0000_00A9 || pc_a !== 32'h10) begin
        errors++;
        $display("FAIL freeze_hold c%0d: req=%b valid=%b inst=%h pc=%h want 0 1 000000a9 00000010",
                 c, bus_a.mem_req, valid_a, inst_a, pc_a);
      end
      if (c == 15) freeze = 1'b0;
    end
    tick();
    checks++;
    if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL unfreeze_req: req=%b valid=%b addr=%h want 1 0 00000010",
               bus_a.mem_req, valid_a, bus_a.mem_addr);
    end
  endtask

  task automatic test_branch_drain();
    reset_a();
    auto_a = 1'b1;
    repeat (4) tick();
    auto_a = 1'b0;
    tick();
    checks++;
    if ({bus_a.mem_req, bus_a.mem_addr} !== {1'b1, 32'h8}) begin
      errors++; $display("FAIL drain_pre: req=%b addr=%h want 1 00000008", bus_a.mem_req, bus_a.mem_addr);
    end
    branch_taken = 1'b1; branch_addr = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    for (int c = 6; c <= 7; c++) begin
      if (c == 7) tick();
      checks++;
      if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h8) begin
        errors++;
        $display("FAIL drain_hold c%0d: req=%b valid=%b addr=%h want 1 0 00000008",
                 c, bus_a.mem_req, valid_a, bus_a.mem_addr);
      end
    end
    ack_a = 1'b1;
    tick();
    checks++;
    if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL drain_redirect: req=%b valid=%b addr=%h want 1 0 00000100",
               bus_a.mem_req, valid_a, bus_a.mem_addr);
    end
    tick();
    ack_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || inst_a !== 32'h1A5 || pc_a !== 32'h104) begin
      errors++;
      $display("FAIL drain_fetch: valid=%b inst=%h pc=%h want 1 000001a5 00000104", valid_a, inst_a, pc_a);
    end
  endtask

  task automatic test_branch_hold_freeze();
    tick();
    checks++;
    if ({bus_a.mem_req, bus_a.mem_addr} !== {1'b1, 32'h104}) begin
      errors++; $display("FAIL bhf_req: req=%b addr=%h want 1 00000104", bus_a.mem_req, bus_a.mem_addr);
    end
    ack_a = 1'b1; freeze = 1'b1;
    tick();
    ack_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || inst_a !== 32'h1A1 || pc_a !== 32'h108) begin
      errors++;
      $display("FAIL bhf_hold: valid=%b inst=%h pc=%h want 1 000001a1 00000108", valid_a, inst_a, pc_a);
    end
    branch_taken = 1'b1; branch_addr = 32'h0000_0040;
    tick();
    branch_taken = 1'b0;
    checks++;
    if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL bhf_flush: req=%b valid=%b addr=%h want 1 0 00000040",
               bus_a.mem_req, valid_a, bus_a.mem_addr);
    end
    freeze = 1'b0; ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || inst_a !== 32'hE5 || pc_a !== 32'h44) begin
      errors++;
      $display("FAIL bhf_fetch: valid=%b inst=%h pc=%h want 1 000000e5 00000044", valid_a, inst_a, pc_a);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    checks++;
    if ({bus_a.mem_req, bus_a.mem_addr} !== {1'b1, 32'h44}) begin
      errors++; $display("FAIL b2b_req: req=%b addr=%h want 1 00000044", bus_a.mem_req, bus_a.mem_addr);
    end
    ack_a = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0203;
    tick();
    branch_taken = 1'b0;
    checks++;
    if ({bus_a.mem_req, valid_a} !== 2'b10 || bus_a.mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL b2b_drop: req=%b valid=%b addr=%h want 1 0 00000200",
               bus_a.mem_req, valid_a, bus_a.mem_addr);
    end
    tick();
    ack_a = 1'b0;
    checks++;
    if (valid_a !== 1'b1 || inst_a !== 32'h2A5 || pc_a !== 32'h204) begin
      errors++;
      $display("FAIL b2b_fetch: valid=%b inst=%h pc=%h want 1 000002a5 00000204", valid_a, inst_a, pc_a);
    end
    tick();
    checks++;
    if ({bus_a.mem_req, bus_a.mem_addr} !== {1'b1, 32'h204}) begin
      errors++; $display("FAIL b2b_next: req=%b addr=%h want 1 00000204", bus_a.mem_req, bus_a.mem_addr);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    rst_b = 1'b0; auto_b = 1'b1; ack_b = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_b.mem_req, valid_b, err_b} !== 3'b000 || pc_b !== 32'd0 || bus_b.mem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_reset: req=%b valid=%b err=%b pc=%h addr=%h want 0 0 0 00000000 fffffffc",
               bus_b.mem_req, valid_b, err_b, pc_b, bus_b.mem_addr);
    end
    rst_b = 1'b1;
    tick();
    checks++;
    if ({bus_b.mem_req, bus_b.mem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", bus_b.mem_req, bus_b.mem_addr);
    end
    tick();
    auto_b = 1'b0;
    checks++;
    if (valid_b !== 1'b1 || inst_b !== 32'hFFFF_FF59 || pc_b !== 32'd0) begin
      errors++;
      $display("FAIL wrap_fetch: valid=%b inst=%h pc=%h want 1 ffffff59 00000000", valid_b, inst_b, pc_b);
    end
    tick();
    checks++;
    if ({bus_b.mem_req, bus_b.mem_addr} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", bus_b.mem_req, bus_b.mem_addr);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({bus_b.mem_req, valid_b, err_b} !== 3'b000 || inst_b !== 32'd0 || pc_b !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: req=%b valid=%b err=%b inst=%h pc=%h want 0 0 0 0 0",
               bus_b.mem_req, valid_b, err_b, inst_b, pc_b);
    end
    ack_b = 1'b1;
    repeat (2) @(negedge clk);
    ack_b = 1'b0;
    rst_b = 1'b1;
    checks++;
    if ({bus_b.mem_req, valid_b} !== 2'b00 || inst_b !== 32'd0) begin
      errors++;
      $display("FAIL late_ack: req=%b valid=%b inst=%h want 0 0 00000000", bus_b.mem_req, valid_b, inst_b);
    end
  endtask

  task automatic test_timeout();
    rst_b = 1'b0; auto_b = 1'b0; ack_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({bus_b.mem_req, err_b} !== 2'b10) begin
        errors++; $display("FAIL tmo_wait c%0d: req=%b err=%b want 1 0", c, bus_b.mem_req, err_b);
      end
    end
    tick();
    checks++;
    if ({bus_b.mem_req, err_b, valid_b} !== 3'b010) begin
      errors++;
      $display("FAIL tmo_err: req=%b err=%b valid=%b want 0 1 0", bus_b.mem_req, err_b, valid_b);
    end
    ack_b = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0080;
    tick();
    branch_taken = 1'b0;
    tick();
    ack_b = 1'b0;
    checks++;
    if ({bus_b.mem_req, err_b, valid_b} !== 3'b010 || bus_b.mem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL tmo_sticky: req=%b err=%b valid=%b addr=%h want 0 1 0 fffffffc",
               bus_b.mem_req, err_b, valid_b, bus_b.mem_addr);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    auto_a = 1'b0; ack_a = 1'b0; auto_b = 1'b0; ack_b = 1'b0;
    branch_taken = 1'b0; branch_addr = 32'd0; freeze = 1'b0;

    test_reset();
    test_zero_wait();
    test_wait_and_freeze();
    test_branch_drain();
    test_branch_hold_freeze();
    test_back_to_back();
    test_wrap_and_async_reset();
    test_timeout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
